// File: rtl/core_job_dispatcher_if.sv
// Job intake and SHA-256 core input signal set for core_job_dispatcher.
// The slave modport is the dispatcher's view; the master modport is the fetcher/core side.
interface core_job_dispatcher_if;
  localparam int unsigned HASH_W = 256;
  localparam int unsigned WORD_W = 32;

  logic              job_valid;
  logic              job_ready;
  logic [HASH_W-1:0] job_hashstate;
  logic [WORD_W-1:0] job_w1;
  logic [WORD_W-1:0] job_w2;
  logic [WORD_W-1:0] job_w3;

  logic              core_valid;
  logic              core_newblock;
  logic [HASH_W-1:0] core_hashstate;
  logic [WORD_W-1:0] core_w1;
  logic [WORD_W-1:0] core_w2;
  logic [WORD_W-1:0] core_w3;

  modport slave (
    input  job_valid, job_hashstate, job_w1, job_w2, job_w3,
    output job_ready,
    output core_valid, core_newblock, core_hashstate, core_w1, core_w2, core_w3
  );

  modport master (
    output job_valid, job_hashstate, job_w1, job_w2, job_w3,
    input  job_ready,
    input  core_valid, core_newblock, core_hashstate, core_w1, core_w2, core_w3
  );
endinterface

// File: rtl/core_job_dispatcher.sv
// Feeds jobs (midstate + 3 tail words) into one SHA-256 core, JOB_LEN valid cycles per job,
// with one active and one pending slot so consecutive jobs issue without a bubble.
module core_job_dispatcher #(
  parameter int unsigned JOB_LEN = 1024,
  parameter int unsigned CNT_W   = $clog2(JOB_LEN) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  core_job_dispatcher_if.slave bus,
  input  logic                 pause,
  input  logic                 abort,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic                 job_done,
  output logic                 busy
);
  localparam int unsigned HASH_W = 256;
  localparam int unsigned WORD_W = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(JOB_LEN - 1);

  typedef struct packed {
    logic [HASH_W-1:0] hashstate;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
  } job_t;

  logic [0:0]       state;
  logic [0:0]       state_n;
  job_t             job_in;
  job_t             act_q;
  job_t             act_n;
  job_t             pend_q;
  job_t             pend_n;
  job_t             core_q;
  job_t             core_n;
  logic             pend_full_q;
  logic             pend_full_n;
  logic             nb_due_q;
  logic             nb_due_n;
  logic             valid_q;
  logic             valid_n;
  logic             nb_q;
  logic             nb_n;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_now;
  logic             done_q;
  logic             done_n;
  logic             busy_q;
  logic             busy_n;
  logic             ready_q;
  logic             ready_n;
  logic             accept;
  logic             last_now;
  logic             fresh;

  assign job_in   = {bus.job_hashstate, bus.job_w1, bus.job_w2, bus.job_w3};
  assign accept   = bus.job_valid && ready_q && !abort;
  // The core is currently seeing the final valid of the active job.
  assign last_now = (state == RUN) && valid_q && (cnt_q == LAST);
  assign cnt_now  = cnt_q + CNT_W'(valid_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, slot management and next output values
  always_comb begin
    state_n     = state;
    act_n       = act_q;
    pend_n      = pend_q;
    pend_full_n = pend_full_q;
    core_n      = core_q;
    nb_due_n    = nb_due_q;
    cnt_n       = cnt_q;
    valid_n     = 1'b0;
    nb_n        = 1'b0;
    done_n      = 1'b0;
    fresh       = 1'b0;

    if (abort) begin
      state_n     = IDLE;
      pend_full_n = 1'b0;
      nb_due_n    = 1'b0;
      cnt_n       = '0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          fresh = 1'b1;
          act_n = job_in;
        end
      end else if (last_now) begin
        // Pending slot wins; otherwise a job accepted right now follows with no bubble.
        if (pend_full_q) begin
          fresh       = 1'b1;
          act_n       = pend_q;
          pend_full_n = 1'b0;
        end else if (accept) begin
          fresh = 1'b1;
          act_n = job_in;
        end
      end else if (accept) begin
        pend_n      = job_in;
        pend_full_n = 1'b1;
      end

      if (fresh) begin
        state_n  = RUN;
        cnt_n    = '0;
        nb_due_n = 1'b1;
      end else if (state == RUN && !last_now) begin
        cnt_n = cnt_now;
      end else begin
        state_n  = IDLE;
        cnt_n    = '0;
        nb_due_n = 1'b0;
      end

      // A newblock withheld by pause stays owed until the first unpaused issue.
      if (state_n == RUN && !pause) begin
        valid_n  = 1'b1;
        nb_n     = nb_due_n;
        nb_due_n = 1'b0;
        if (nb_n) begin
          core_n = act_n;
        end
      end

      done_n = valid_n && (cnt_n == LAST);
    end

    ready_n = !pend_full_n && !abort;
    busy_n  = (state_n == RUN);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q       <= '0;
      pend_q      <= '0;
      core_q      <= '0;
      pend_full_q <= 1'b0;
      nb_due_q    <= 1'b0;
      valid_q     <= 1'b0;
      nb_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      act_q       <= act_n;
      pend_q      <= pend_n;
      core_q      <= core_n;
      pend_full_q <= pend_full_n;
      nb_due_q    <= nb_due_n;
      valid_q     <= valid_n;
      nb_q        <= nb_n;
      cnt_q       <= cnt_n;
      done_q      <= done_n;
      busy_q      <= busy_n;
      ready_q     <= ready_n;
    end
  end

  assign bus.job_ready      = ready_q;
  assign bus.core_valid     = valid_q;
  assign bus.core_newblock  = nb_q;
  assign bus.core_hashstate = core_q.hashstate;
  assign bus.core_w1        = core_q.w1;
  assign bus.core_w2        = core_q.w2;
  assign bus.core_w3        = core_q.w3;
  assign issue_cnt          = cnt_q;
  assign job_done           = done_q;
  assign busy               = busy_q;
endmodule

// File: tb/tb_core_job_dispatcher.sv
// Directed bench for core_job_dispatcher with JOB_LEN=4; expected values are hand-derived per cycle.
module tb_core_job_dispatcher;
  localparam int unsigned JOB_LEN = 4;
  localparam int unsigned CNT_W   = $clog2(JOB_LEN) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             pause;
  logic             abort;
  logic [CNT_W-1:0] issue_cnt;
  logic             job_done;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  core_job_dispatcher_if bus();

  core_job_dispatcher #(.JOB_LEN(JOB_LEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pause     (pause),
    .abort     (abort),
    .issue_cnt (issue_cnt),
    .job_done  (job_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Key 0 stands for the all-zero post-reset payload.
  function automatic logic [255:0] hs_of(input logic [7:0] k);
    return (k == 8'd0) ? 256'd0 : {8{24'hC0DE00, k}};
  endfunction

  function automatic logic [31:0] w_of(input logic [7:0] k, input logic [7:0] n);
    return (k == 8'd0) ? 32'd0 : {n, 16'h5A5A, k};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] k);
    bus.job_valid     = 1'b1;
    bus.job_hashstate = hs_of(k);
    bus.job_w1        = w_of(k, 8'd1);
    bus.job_w2        = w_of(k, 8'd2);
    bus.job_w3        = w_of(k, 8'd3);
  endtask

  task automatic expect_cycle(input string tag, input bit v, input bit nb, input int cnt,
                              input bit done, input bit bsy, input logic [7:0] k);
    check({tag, ".valid"}, 256'(bus.core_valid), 256'(v));
    check({tag, ".newblock"}, 256'(bus.core_newblock), 256'(nb));
    check({tag, ".issue_cnt"}, 256'(issue_cnt), 256'(cnt));
    check({tag, ".job_done"}, 256'(job_done), 256'(done));
    check({tag, ".busy"}, 256'(busy), 256'(bsy));
    check({tag, ".hashstate"}, bus.core_hashstate, hs_of(k));
    check({tag, ".w1"}, 256'(bus.core_w1), 256'(w_of(k, 8'd1)));
    check({tag, ".w3"}, 256'(bus.core_w3), 256'(w_of(k, 8'd3)));
  endtask

  // Wait (bounded) for the active job to finish, then leave one idle cycle.
  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".drain"}, 256'(busy), 256'(0));
    tick();
  endtask

  task automatic single_job(input string tag, input logic [7:0] k);
    offer(k);
    check({tag, ".ready"}, 256'(bus.job_ready), 256'(1));
    tick();
    bus.job_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("%s.c%0d", tag, i + 1), 1'b1, i == 0, i, i == 3, 1'b1, k);
      tick();
    end
    expect_cycle({tag, ".after"}, 1'b0, 1'b0, 0, 1'b0, 1'b0, k);
  endtask

  initial begin
    bit vexp[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int cexp[6] = '{0, 1, 2, 2, 2, 3};
    int nv;

    rst               = 1'b1;
    pause             = 1'b0;
    abort             = 1'b0;
    bus.job_valid     = 1'b0;
    bus.job_hashstate = '0;
    bus.job_w1        = '0;
    bus.job_w2        = '0;
    bus.job_w3        = '0;
    tick();
    tick();
    expect_cycle("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd0);
    check("reset.ready", 256'(bus.job_ready), 256'(1));
    rst = 1'b0;
    tick();

    // Test 1: single job
    single_job("t1", 8'd1);
    tick();

    // Test 2: B accepted during A -> 8 contiguous valids, switch at cycle 5
    offer(8'd2);
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_cycle($sformatf("t2.c%0d", i + 1), 1'b1, (i % 4) == 0, i % 4, (i % 4) == 3, 1'b1,
                   (i < 4) ? 8'd2 : 8'd3);
      if (i == 1) check("t2.ready_full", 256'(bus.job_ready), 256'(0));
      if (i == 0) offer(8'd3);
      else bus.job_valid = 1'b0;
      tick();
    end
    expect_cycle("t2.after", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd3);
    tick();

    // Test 3: pause during cycles 2-3 -> gaps on cycles 3-4 with issue_cnt frozen at 2
    offer(8'd4);
    tick();
    bus.job_valid = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      expect_cycle($sformatf("t3.c%0d", i + 1), vexp[i], i == 0, cexp[i], i == 5, 1'b1, 8'd4);
      if (bus.core_valid) nv++;
      pause = (i == 1 || i == 2);
      tick();
    end
    pause = 1'b0;
    check("t3.valid_total", 256'(nv), 256'(4));
    expect_cycle("t3.after", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd4);

    // Test 3b: pause on the accept cycle defers the newblock
    offer(8'd5);
    pause = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    expect_cycle("t3b.held", 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'd4);
    pause = 1'b0;
    tick();
    expect_cycle("t3b.first", 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'd5);
    drain("t3b");

    // Test 4: both slots full, third job held until the pending slot frees
    offer(8'd6);
    tick();
    offer(8'd7);
    expect_cycle("t4.c1", 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'd6);
    tick();
    offer(8'd8);
    check("t4.c2.ready", 256'(bus.job_ready), 256'(0));
    expect_cycle("t4.c2", 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'd6);
    tick();
    check("t4.c3.ready", 256'(bus.job_ready), 256'(0));
    tick();
    check("t4.c4.ready", 256'(bus.job_ready), 256'(0));
    check("t4.c4.done", 256'(job_done), 256'(1));
    tick();
    check("t4.c5.ready", 256'(bus.job_ready), 256'(1));
    expect_cycle("t4.c5", 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'd7);
    tick();
    bus.job_valid = 1'b0;
    check("t4.c6.ready", 256'(bus.job_ready), 256'(0));
    expect_cycle("t4.c6", 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'd7);
    tick();
    tick();
    tick();
    expect_cycle("t4.c9", 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'd8);
    drain("t4");

    // Test 5: abort at issue_cnt=2 with pending full
    offer(8'd9);
    tick();
    offer(8'd10);
    tick();
    bus.job_valid = 1'b0;
    tick();
    expect_cycle("t5.c3", 1'b1, 1'b0, 2, 1'b0, 1'b1, 8'd9);
    abort = 1'b1;
    offer(8'd11);
    tick();
    abort = 1'b0;
    bus.job_valid = 1'b0;
    expect_cycle("t5.c4", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd9);
    tick();
    check("t5.c5.ready", 256'(bus.job_ready), 256'(1));
    expect_cycle("t5.c5", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd9);
    tick();
    expect_cycle("t5.c6", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd9);

    // Test 5b: job offered while idle during abort is not taken
    offer(8'd12);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.job_valid = 1'b0;
    expect_cycle("t5b.c1", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd9);
    tick();
    expect_cycle("t5b.c2", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd9);

    // Test 6: rst mid-job clears everything, then a normal job runs
    offer(8'd13);
    tick();
    bus.job_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_cycle("t6.rst", 1'b0, 1'b0, 0, 1'b0, 1'b0, 8'd0);
    check("t6.rst.ready", 256'(bus.job_ready), 256'(1));
    single_job("t6", 8'd14);
    tick();

    // Test 7: job accepted on the last valid follows with zero bubble
    offer(8'd15);
    tick();
    bus.job_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t7.c4.done", 256'(job_done), 256'(1));
    check("t7.c4.ready", 256'(bus.job_ready), 256'(1));
    offer(8'd16);
    tick();
    bus.job_valid = 1'b0;
    expect_cycle("t7.c5", 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'd16);
    drain("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
